// File: rtl/mr_ls.sv
// Load/store stage: passes ALU results to writeback, or performs one
// aligned data-memory access per entry and returns load data to writeback.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef REGSEL_BITS
`define REGSEL_BITS 5
`endif

package mr_ls_pkg;
    typedef enum logic [1:0] {
        MEMOP_NONE  = 2'd0,
        MEMOP_LOAD  = 2'd1,
        MEMOP_STORE = 2'd2
    } e_memops;

    typedef enum logic [1:0] {
        MEMSZ_B = 2'd0,
        MEMSZ_H = 2'd1,
        MEMSZ_W = 2'd2
    } e_memsz;
endpackage

module mr_ls
    import mr_ls_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ls_valid,
    output logic                    ls_ready,
    input  logic [`XLEN-1:0]        ls_dest,
    input  logic [`REGSEL_BITS-1:0] ls_dest_reg,
    input  e_memops                 ls_memop,
    input  e_memsz                  ls_size,
    input  logic                    ls_signed,
    input  logic [`XLEN-1:0]        ls_payload,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [`XLEN-1:0]        mem_addr,
    output logic [`XLEN-1:0]        mem_wdata,
    output logic [3:0]              mem_wstrb,
    input  logic                    mem_ack,
    input  logic [`XLEN-1:0]        mem_rdata,
    output logic                    wb_valid,
    output logic [`REGSEL_BITS-1:0] wb_reg,
    output logic [`XLEN-1:0]        wb_data,
    output logic                    ls_fault,
    output logic [`XLEN-1:0]        ls_fault_addr
);

    typedef enum logic {S_IDLE, S_BUS} state_t;

    state_t                  state;
    logic                    accept;
    e_memsz                  size_p1;
    logic                    sgn_p1;
    logic [1:0]              off_p1;
    logic                    load_p1;
    logic [`REGSEL_BITS-1:0] dreg_p1;

    function automatic logic misaligned(input e_memsz sz, input logic [1:0] off);
        case (sz)
            MEMSZ_B: misaligned = 1'b0;
            MEMSZ_H: misaligned = off[0];
            default: misaligned = (off != 2'b00);
        endcase
    endfunction

    function automatic logic [`XLEN-1:0] store_data(input e_memsz sz, input logic [`XLEN-1:0] p);
        case (sz)
            MEMSZ_B: store_data = {4{p[7:0]}};
            MEMSZ_H: store_data = {2{p[15:0]}};
            default: store_data = p;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input e_memsz sz, input logic [1:0] off);
        case (sz)
            MEMSZ_B: store_strb = 4'b0001 << off;
            MEMSZ_H: store_strb = 4'b0011 << off;
            default: store_strb = 4'b1111;
        endcase
    endfunction

    function automatic logic [`XLEN-1:0] load_extract(input e_memsz sz, input logic sgn,
                                                      input logic [1:0] off,
                                                      input logic [`XLEN-1:0] rdata);
        logic [`XLEN-1:0]  sh;
        logic signed [7:0]  b_s;
        logic signed [15:0] h_s;
        sh  = rdata >> {off, 3'b000};
        b_s = sh[7:0];
        h_s = sh[15:0];
        case (sz)
            MEMSZ_B: load_extract = sgn ? {{24{b_s[7]}}, b_s} : {24'b0, sh[7:0]};
            MEMSZ_H: load_extract = sgn ? {{16{h_s[15]}}, h_s} : {16'b0, sh[15:0]};
            default: load_extract = rdata;
        endcase
    endfunction

    assign ls_ready = !rst && (state == S_IDLE);
    assign accept   = ls_valid && ls_ready;

    // p1: access attributes held while the bus transaction is outstanding
    always_ff @(posedge clk) begin
        if (accept) begin
            size_p1 <= ls_size;
            sgn_p1  <= ls_signed;
            off_p1  <= ls_dest[1:0];
            load_p1 <= (ls_memop == MEMOP_LOAD);
            dreg_p1 <= ls_dest_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wstrb     <= 4'b0000;
            wb_valid      <= 1'b0;
            wb_reg        <= '0;
            wb_data       <= '0;
            ls_fault      <= 1'b0;
            ls_fault_addr <= '0;
        end else begin
            wb_valid <= 1'b0;
            ls_fault <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (ls_memop != MEMOP_LOAD && ls_memop != MEMOP_STORE) begin
                            wb_valid <= (ls_dest_reg != '0);
                            wb_reg   <= ls_dest_reg;
                            wb_data  <= ls_dest;
                        end else if (misaligned(ls_size, ls_dest[1:0])) begin
                            ls_fault      <= 1'b1;
                            ls_fault_addr <= ls_dest;
                        end else begin
                            state    <= S_BUS;
                            mem_req  <= 1'b1;
                            mem_addr <= {ls_dest[`XLEN-1:2], 2'b00};
                            if (ls_memop == MEMOP_STORE) begin
                                mem_we    <= 1'b1;
                                mem_wdata <= store_data(ls_size, ls_payload);
                                mem_wstrb <= store_strb(ls_size, ls_dest[1:0]);
                            end else begin
                                mem_we    <= 1'b0;
                                mem_wdata <= '0;
                                mem_wstrb <= 4'b0000;
                            end
                        end
                    end
                end
                S_BUS: begin
                    // an ack ends the transaction; only loads write a register
                    if (mem_ack) begin
                        state   <= S_IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (load_p1) begin
                            wb_valid <= (dreg_p1 != '0);
                            wb_reg   <= dreg_p1;
                            wb_data  <= load_extract(size_p1, sgn_p1, off_p1, mem_rdata);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mr_ls.sv
// Scoreboard bench for mr_ls: stimulus pushes expectations, monitors and a
// memory responder pop and compare whatever the DUT presents.
module tb_mr_ls;
    import mr_ls_pkg::*;

    logic        clk, rst, ls_valid, ls_ready, ls_signed;
    logic [31:0] ls_dest, ls_payload;
    logic [4:0]  ls_dest_reg;
    e_memops     ls_memop;
    e_memsz      ls_size;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        wb_valid, ls_fault;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data, ls_fault_addr;

    mr_ls dut (
        .clk(clk), .rst(rst), .ls_valid(ls_valid), .ls_ready(ls_ready),
        .ls_dest(ls_dest), .ls_dest_reg(ls_dest_reg), .ls_memop(ls_memop),
        .ls_size(ls_size), .ls_signed(ls_signed), .ls_payload(ls_payload),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_reg(wb_reg),
        .wb_data(wb_data), .ls_fault(ls_fault), .ls_fault_addr(ls_fault_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } bus_t;
    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } wb_t;

    bus_t        bus_q[$];
    wb_t         wb_q[$];
    logic [31:0] fault_q[$];
    bit   [31:0] ref_mem[bit [31:0]];
    bit   [31:0] bus_mem[bit [31:0]];
    int          tests = 0;
    int          fails = 0;
    int          force_delay = -1;

    function automatic bit [31:0] hash(input bit [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC3A55A3C;
    endfunction
    function automatic bit [31:0] ref_rd(input bit [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : hash(a);
    endfunction
    function automatic bit [31:0] bus_rd(input bit [31:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : hash(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        tests++;
        fails++;
        $display("FAIL %s: unexpected output %h at %0t", name, act, $time);
    endtask

    // Writeback / fault monitor
    always @(negedge clk) begin
        if (wb_valid === 1'b1 && ls_fault === 1'b1) unexpected("wb_and_fault", 32'h1);
        if (wb_valid === 1'b1) begin
            if (wb_q.size() == 0) unexpected("wb_extra", wb_data);
            else begin
                wb_t e;
                e = wb_q.pop_front();
                check("wb_reg", 32'(wb_reg), 32'(e.r));
                check("wb_data", wb_data, e.d);
            end
        end
        if (ls_fault === 1'b1) begin
            if (fault_q.size() == 0) unexpected("fault_extra", ls_fault_addr);
            else check("fault_addr", ls_fault_addr, fault_q.pop_front());
        end
    end

    // Memory responder and bus request checker
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1 && rst === 1'b0) begin
                bus_t seen;
                int   d;
                seen = '{we: mem_we, addr: mem_addr, wdata: mem_wdata, strb: mem_wstrb};
                if (bus_q.size() == 0) unexpected("bus_extra", mem_addr);
                else begin
                    bus_t e;
                    e = bus_q.pop_front();
                    check("mem_we", 32'(mem_we), 32'(e.we));
                    check("mem_addr", mem_addr, e.addr);
                    check("mem_wstrb", 32'(mem_wstrb), 32'(e.strb));
                    if (e.we) check("mem_wdata", mem_wdata, e.wdata);
                end
                d = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
                repeat (d) @(negedge clk);
                if (mem_req === 1'b1) begin
                    check("hold_addr", mem_addr, seen.addr);
                    check("hold_wstrb", 32'(mem_wstrb), 32'(seen.strb));
                end
                mem_ack   = 1'b1;
                mem_rdata = bus_rd(seen.addr);
                @(negedge clk);
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
                if (seen.we) begin
                    bit [31:0] w;
                    w = bus_rd(seen.addr);
                    for (int i = 0; i < 4; i++)
                        if (seen.strb[i]) w[8*i +: 8] = seen.wdata[8*i +: 8];
                    bus_mem[seen.addr] = w;
                end
            end
        end
    end

    // Pushes expectations from a byte-level model of memory and the access rules
    task automatic model(input e_memops op, input e_memsz sz, input bit sgn,
                         input logic [31:0] a, input logic [31:0] p, input logic [4:0] r);
        int          off;
        bit [31:0]   wa, w, v;
        bit          mis;
        off = int'(a[1:0]);
        wa  = {a[31:2], 2'b00};
        mis = (sz == MEMSZ_H && a[0]) || (sz == MEMSZ_W && off != 0);
        if (op != MEMOP_LOAD && op != MEMOP_STORE) begin
            if (r != 0) wb_q.push_back('{r: r, d: a});
        end else if (mis) begin
            fault_q.push_back(a);
        end else if (op == MEMOP_LOAD) begin
            bus_q.push_back('{we: 1'b0, addr: wa, wdata: 32'h0, strb: 4'h0});
            w = ref_rd(wa);
            if (sz == MEMSZ_B) begin
                v = {24'h0, w[8*off +: 8]};
                if (sgn && v[7]) v[31:8] = '1;
            end else if (sz == MEMSZ_H) begin
                v = {16'h0, w[8*off +: 16]};
                if (sgn && v[15]) v[31:16] = '1;
            end else v = w;
            if (r != 0) wb_q.push_back('{r: r, d: v});
        end else begin
            w = ref_rd(wa);
            if (sz == MEMSZ_B) begin
                bus_q.push_back('{we: 1'b1, addr: wa, wdata: {4{p[7:0]}}, strb: 4'b0001 << off});
                w[8*off +: 8] = p[7:0];
            end else if (sz == MEMSZ_H) begin
                bus_q.push_back('{we: 1'b1, addr: wa, wdata: {2{p[15:0]}}, strb: 4'b0011 << off});
                w[8*off +: 16] = p[15:0];
            end else begin
                bus_q.push_back('{we: 1'b1, addr: wa, wdata: p, strb: 4'b1111});
                w = p;
            end
            ref_mem[wa] = w;
        end
    endtask

    task automatic issue(input e_memops op, input e_memsz sz, input bit sgn,
                         input logic [31:0] a, input logic [31:0] p, input logic [4:0] r,
                         input bit auto_exp);
        int n;
        @(negedge clk);
        ls_valid = 1'b1; ls_memop = op; ls_size = sz; ls_signed = sgn;
        ls_dest = a; ls_payload = p; ls_dest_reg = r;
        n = 0;
        while (ls_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            unexpected("ready_timeout", a);
            ls_valid = 1'b0;
        end else begin
            if (auto_exp) model(op, sz, sgn, a, p, r);
            @(posedge clk);
            #1 ls_valid = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1'b1; ls_valid = 1'b0; ls_memop = MEMOP_NONE; ls_size = MEMSZ_B;
        ls_signed = 1'b0; ls_dest = '0; ls_payload = '0; ls_dest_reg = '0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {28'h0, mem_req, mem_we, wb_valid, ls_fault}, 32'h0);
        check("rst_ready", 32'(ls_ready), 32'h0);
        check("rst_wstrb", 32'(mem_wstrb), 32'h0);
        check("rst_data", mem_addr | mem_wdata | wb_data | ls_fault_addr | 32'(wb_reg), 32'h0);
        rst = 1'b0;

        // ALU passthrough, back-to-back, and x0 suppression
        issue(MEMOP_NONE, MEMSZ_W, 1'b0, 32'h11, 32'h0, 5'd5, 1'b1);
        issue(MEMOP_NONE, MEMSZ_W, 1'b0, 32'h22, 32'h0, 5'd6, 1'b1);
        issue(MEMOP_NONE, MEMSZ_W, 1'b0, 32'h33, 32'h0, 5'd0, 1'b1);

        // LW with ack three cycles after mem_req
        ref_mem[32'h1000] = 32'hDEADBEEF; bus_mem[32'h1000] = 32'hDEADBEEF;
        bus_q.push_back('{we: 1'b0, addr: 32'h1000, wdata: 32'h0, strb: 4'h0});
        wb_q.push_back('{r: 5'd7, d: 32'hDEADBEEF});
        force_delay = 3;
        issue(MEMOP_LOAD, MEMSZ_W, 1'b0, 32'h1000, 32'h0, 5'd7, 1'b0);
        n = 0;
        @(negedge clk);
        while (ls_ready !== 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("lw_ready_low_cycles", 32'(n), 32'd4);
        check("lw_wb_with_ready", 32'(wb_valid), 32'h1);
        force_delay = -1;

        // LB / LBU from the top byte lane
        ref_mem[32'h1000] = 32'h80123456; bus_mem[32'h1000] = 32'h80123456;
        bus_q.push_back('{we: 1'b0, addr: 32'h1000, wdata: 32'h0, strb: 4'h0});
        wb_q.push_back('{r: 5'd8, d: 32'hFFFFFF80});
        issue(MEMOP_LOAD, MEMSZ_B, 1'b1, 32'h1003, 32'h0, 5'd8, 1'b0);
        bus_q.push_back('{we: 1'b0, addr: 32'h1000, wdata: 32'h0, strb: 4'h0});
        wb_q.push_back('{r: 5'd9, d: 32'h00000080});
        issue(MEMOP_LOAD, MEMSZ_B, 1'b0, 32'h1003, 32'h0, 5'd9, 1'b0);

        // SB: replicated data, single-lane strobe, no writeback
        bus_q.push_back('{we: 1'b1, addr: 32'h2000, wdata: 32'hABABABAB, strb: 4'b0100});
        issue(MEMOP_STORE, MEMSZ_B, 1'b0, 32'h2002, 32'h000000AB, 5'd10, 1'b0);

        // Misaligned LW and SH fault without touching the bus
        fault_q.push_back(32'h1002);
        issue(MEMOP_LOAD, MEMSZ_W, 1'b0, 32'h1002, 32'h0, 5'd11, 1'b0);
        fault_q.push_back(32'h3001);
        issue(MEMOP_STORE, MEMSZ_H, 1'b0, 32'h3001, 32'h1234, 5'd12, 1'b0);
        repeat (3) @(negedge clk);

        // Reset while the bus access is pending; the late ack must be ignored
        bus_q.push_back('{we: 1'b0, addr: 32'h5000, wdata: 32'h0, strb: 4'h0});
        force_delay = 5;
        issue(MEMOP_LOAD, MEMSZ_W, 1'b0, 32'h5000, 32'h0, 5'd3, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("rst_drops_req", 32'(mem_req), 32'h0);
        check("rst_ready_low", 32'(ls_ready), 32'h0);
        rst = 1'b0;
        #1 check("ready_after_rst", 32'(ls_ready), 32'h1);
        repeat (10) @(negedge clk);
        force_delay = -1;

        // Randomized mix checked against the byte-level model
        for (int i = 0; i < 300; i++) begin
            e_memops op;
            e_memsz  sz;
            op = e_memops'(2'($urandom_range(0, 2)));
            sz = e_memsz'(2'($urandom_range(0, 2)));
            issue(op, sz, 1'($urandom), 32'h4000 + 32'($urandom_range(0, 31)),
                  $urandom, 5'($urandom), 1'b1);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        repeat (20) @(negedge clk);
        check("wb_q_drained", 32'(wb_q.size()), 32'h0);
        check("bus_q_drained", 32'(bus_q.size()), 32'h0);
        check("fault_q_drained", 32'(fault_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
